store_merge_unit: RTL and testbench
===================================

STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1, meaning cycles from mem_rd assertion to valid mem_rdata; legal range 1..4.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  store request, sampled only in IDLE.
REQ-005 SHALL have port size  input  2  store size: 00 word, 01 halfword, 10 byte, 11 illegal.
REQ-006 SHALL have port addr  input  32  byte address of the store.
REQ-007 SHALL have port wdata  input  32  source register value; the low byte or low halfword is used for narrow stores.
REQ-008 SHALL have port mem_rdata  input  32  memory read word.
REQ-009 SHALL have port mem_addr  output  32  word-aligned memory address.
REQ-010 SHALL have port mem_rd  output  1  memory read strobe.
REQ-011 SHALL have port mem_wr  output  1  memory write strobe.
REQ-012 SHALL have port mem_wdata  output  32  word to be written.
REQ-013 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port misalign  output  1  one-cycle error pulse.

Function
REQ-016 SHALL implement the FSM states IDLE, READ, WAIT, WRITE, DONE and ERR.
REQ-017 SHALL, in IDLE with start=1, latch size, addr and wdata, and set mem_addr={addr[31:2],2'b00}.
REQ-018 SHALL hold mem_addr stable until the next accepted start.
REQ-019 SHALL ignore start in every state other than IDLE.
REQ-020 SHALL treat a request as illegal when size=11, or size=00 with addr[1:0]!=00, or size=01 with addr[0]=1.
REQ-021 SHALL, for an illegal request, go IDLE->ERR, assert misalign for the one ERR cycle, then return to IDLE.
REQ-022 SHALL issue no mem_rd and no mem_wr for an illegal request.
REQ-023 SHALL, for a word store, go IDLE->WRITE->DONE->IDLE.
REQ-024 SHALL, for a word store, drive mem_wdata=latched wdata with no read performed.
REQ-025 SHALL, for a byte or halfword store, go IDLE->READ->WAIT->WRITE->DONE->IDLE, performing a read-modify-write.
REQ-026 SHALL, in READ, assert mem_rd for exactly one cycle.
REQ-027 SHALL stay in WAIT for exactly RD_LATENCY cycles, using a down-counter loaded on entry to WAIT.
REQ-028 SHALL capture mem_rdata into an internal register at the end of the last WAIT cycle.
REQ-029 SHALL, in WRITE, assert mem_wr for exactly one cycle.
REQ-030 SHALL, in WRITE, drive mem_wdata equal to the captured word with the target lane replaced.
REQ-031 SHALL use big-endian lane selection.
REQ-032 SHALL place byte offset k (k=addr[1:0]) at bits [31-8k : 24-8k].
REQ-033 SHALL place halfword offset 0 at bits [31:16] and halfword offset 2 at bits [15:0].
REQ-034 SHALL leave every non-target bit of the written word equal to the captured mem_rdata.
REQ-035 SHALL never assert mem_rd and mem_wr in the same cycle.
REQ-036 SHALL assert done only in the DONE state.
REQ-037 SHALL accept a new start in the cycle immediately after DONE.
REQ-038 SHALL make the latency from the start cycle (cycle 0) to the done cycle 2 for a word store, RD_LATENCY+3 for a narrow store, and 1 for an illegal request (the misalign pulse).
REQ-039 SHALL drive mem_wdata to zero outside WRITE.

Reset
REQ-040 SHALL, while reset=1 at a rising edge, force state IDLE; mem_addr, mem_wdata, the capture register and the WAIT counter to 0; and mem_rd, mem_wr, busy, done and misalign to 0.
REQ-041 SHALL abandon any operation in progress when reset is asserted mid-operation.
REQ-042 SHALL issue no mem_wr in the cycle following a reset.
REQ-043 SHALL ignore start while reset=1.

Verification
REQ-044 SHALL cover the word store: addr=0x100, size=00, wdata=0xDEADBEEF -> cycle 1 mem_wr=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; cycle 2 done=1; mem_rd never asserted.
REQ-045 SHALL cover the byte store with RD_LATENCY=1: addr=0x203, size=10, wdata=0x000000AB, memory word 0x11223344 -> cycle 1 mem_rd=1, mem_addr=0x200; cycle 3 mem_wr=1, mem_wdata=0x112233AB; cycle 4 done=1.
REQ-046 SHALL cover the halfword store with RD_LATENCY=3: addr=0x40, size=01, wdata=0xFFFF1234, memory word 0xAABBCCDD -> mem_wdata=0x1234CCDD; done in cycle 6.
REQ-047 SHALL cover the misalignment set: (size=01, addr=0x41), (size=00, addr=0x42) and (size=11, any addr) -> misalign=1 in cycle 1, no mem_rd or mem_wr, busy=0 in cycle 2.
REQ-048 SHALL cover reset mid-operation: reset=1 during WAIT of a byte store -> next cycle busy=0, mem_wr=0, and a new start is accepted one cycle after reset is released.
REQ-049 SHALL cover start while busy: start pulsed during WAIT with a different addr -> ignored, and mem_addr and mem_wdata reflect only the first request.

Source files
------------

// File: rtl/store_merge_unit.sv
// Store unit that issues aligned word writes directly and performs a
// read-modify-write for byte/halfword stores using big-endian lane placement.
module store_merge_unit #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        misalign
);

  localparam int unsigned CNT_W = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  logic [2:0]       r_state;
  logic [1:0]       r_size;
  logic [1:0]       r_off;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_mem_addr;
  logic             r_mem_rd;
  logic             r_mem_wr;
  logic [31:0]      r_mem_wdata;
  logic             r_busy;
  logic             r_done;
  logic             r_misalign;

  logic [2:0]       w_state_nxt;
  logic [1:0]       w_size_nxt;
  logic [1:0]       w_off_nxt;
  logic [31:0]      w_wdata_nxt;
  logic [31:0]      w_rdata_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      w_addr_nxt;
  logic [31:0]      w_merged;
  logic             w_illegal;

  assign w_illegal = (size == 2'b11) ||
                     ((size == 2'b00) && (addr[1:0] != 2'b00)) ||
                     ((size == 2'b01) && addr[0]);

  // Next-state and next-datapath values
  always_comb begin
    w_state_nxt = r_state;
    w_size_nxt  = r_size;
    w_off_nxt   = r_off;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_mem_addr;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_size_nxt  = size;
          w_off_nxt   = addr[1:0];
          w_wdata_nxt = wdata;
          w_addr_nxt  = {addr[31:2], 2'b00};
          if (w_illegal)              w_state_nxt = S_ERR;
          else if (size == 2'b00)     w_state_nxt = S_WRITE;
          else                        w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = CNT_W'(RD_LATENCY);
      end
      S_WAIT: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = S_WRITE;
          w_rdata_nxt = mem_rdata;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      S_WRITE: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Big-endian lane replacement over the word being captured this cycle
  always_comb begin
    w_merged = w_rdata_nxt;
    if (w_size_nxt == 2'b00) begin
      w_merged = w_wdata_nxt;
    end else if (w_size_nxt == 2'b01) begin
      if (w_off_nxt[1]) w_merged[15:0]  = w_wdata_nxt[15:0];
      else              w_merged[31:16] = w_wdata_nxt[15:0];
    end else begin
      case (w_off_nxt)
        2'd0:    w_merged[31:24] = w_wdata_nxt[7:0];
        2'd1:    w_merged[23:16] = w_wdata_nxt[7:0];
        2'd2:    w_merged[15:8]  = w_wdata_nxt[7:0];
        default: w_merged[7:0]   = w_wdata_nxt[7:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_size      <= '0;
      r_off       <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_size      <= w_size_nxt;
      r_off       <= w_off_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rdata     <= w_rdata_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_rd    <= (w_state_nxt == S_READ);
      r_mem_wr    <= (w_state_nxt == S_WRITE);
      r_mem_wdata <= (w_state_nxt == S_WRITE) ? w_merged : 32'd0;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
      r_misalign  <= (w_state_nxt == S_ERR);
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign misalign  = r_misalign;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: one instance at RD_LATENCY=1 and one at 3,
// sharing request inputs, each with its own latency-accurate memory model.
module tb_store_merge_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] mem_rdata1, mem_rdata3, mem_addr1, mem_addr3, mem_wdata1, mem_wdata3;
  logic        mem_rd1, mem_rd3, mem_wr1, mem_wr3;
  logic        busy1, busy3, done1, done3, misalign1, misalign3;
  logic [31:0] mem_word1 = 32'h0, mem_word3 = 32'h0;
  logic [2:0]  rd_pipe1 = 3'b0, rd_pipe3 = 3'b0;

  int checks = 0;
  int errors = 0;
  int rd_cnt1 = 0, wr_cnt1 = 0, rd_cnt3 = 0, wr_cnt3 = 0, overlap = 0;
  int b_rd1, b_wr1, b_rd3, b_wr3;

  logic [1:0]  lane_size [5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
  logic [31:0] lane_addr [5] = '{32'h300, 32'h301, 32'h302, 32'h302, 32'h300};
  logic [31:0] lane_wd   [5] = '{32'h55, 32'h66, 32'h77, 32'h9876, 32'hABCD};
  logic [31:0] lane_exp  [5] = '{32'h55223344, 32'h11663344, 32'h11227744,
                                 32'h11229876, 32'hABCD3344};
  logic [1:0]  mis_size  [3] = '{2'b01, 2'b00, 2'b11};
  logic [31:0] mis_addr  [3] = '{32'h41, 32'h42, 32'h1234};

  always #5 clk = ~clk;

  store_merge_unit #(.RD_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr),
    .wdata(wdata), .mem_rdata(mem_rdata1), .mem_addr(mem_addr1),
    .mem_rd(mem_rd1), .mem_wr(mem_wr1), .mem_wdata(mem_wdata1),
    .busy(busy1), .done(done1), .misalign(misalign1)
  );

  store_merge_unit #(.RD_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr),
    .wdata(wdata), .mem_rdata(mem_rdata3), .mem_addr(mem_addr3),
    .mem_rd(mem_rd3), .mem_wr(mem_wr3), .mem_wdata(mem_wdata3),
    .busy(busy3), .done(done3), .misalign(misalign3)
  );

  // Memory returns valid data only RD_LATENCY cycles after the read strobe
  always @(posedge clk) begin
    rd_pipe1 <= {rd_pipe1[1:0], mem_rd1};
    rd_pipe3 <= {rd_pipe3[1:0], mem_rd3};
  end
  assign mem_rdata1 = rd_pipe1[0] ? mem_word1 : 32'h5A5A5A5A;
  assign mem_rdata3 = rd_pipe3[2] ? mem_word3 : 32'h5A5A5A5A;

  always @(negedge clk) begin
    if (mem_rd1) rd_cnt1++;
    if (mem_wr1) wr_cnt1++;
    if (mem_rd3) rd_cnt3++;
    if (mem_wr3) wr_cnt3++;
    if ((mem_rd1 && mem_wr1) || (mem_rd3 && mem_wr3)) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle (cycle 0); returns positioned in cycle 1
  task automatic do_start(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    size  = sz;
    addr  = a;
    wdata = wd;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; size = 2'b00; addr = 32'h100; wdata = 32'h1;
    repeat (3) step();
    check("rst_busy",     32'(busy1),     32'h0);
    check("rst_mem_rd",   32'(mem_rd1),   32'h0);
    check("rst_mem_wr",   32'(mem_wr1),   32'h0);
    check("rst_done",     32'(done1),     32'h0);
    check("rst_misalign", 32'(misalign3), 32'h0);
    check("rst_mem_addr", mem_addr1,      32'h0);
    check("rst_wdata",    mem_wdata3,     32'h0);
    start = 1'b0; reset = 1'b0;
    step();
    check("post_rst_idle", 32'(busy1), 32'h0);

    // Word store
    b_rd1 = rd_cnt1;
    do_start(2'b00, 32'h100, 32'hDEADBEEF);
    check("word_c1_wr",    32'(mem_wr1), 32'h1);
    check("word_c1_addr",  mem_addr1,    32'h100);
    check("word_c1_wdata", mem_wdata1,   32'hDEADBEEF);
    step();
    check("word_c2_done",  32'(done1),   32'h1);
    check("word_c2_wr",    32'(mem_wr1), 32'h0);
    check("word_c2_wdata", mem_wdata1,   32'h0);
    step();
    check("word_c3_busy",  32'(busy1),   32'h0);
    check("word_no_rd",    32'(rd_cnt1 - b_rd1), 32'h0);

    // Byte store, RD_LATENCY=1
    mem_word1 = 32'h11223344; mem_word3 = 32'h11223344;
    b_rd1 = rd_cnt1;
    do_start(2'b10, 32'h203, 32'h000000AB);
    check("byte_c1_rd",   32'(mem_rd1), 32'h1);
    check("byte_c1_addr", mem_addr1,    32'h200);
    step();
    check("byte_c2_rd",   32'(mem_rd1), 32'h0);
    check("byte_c2_wr",   32'(mem_wr1), 32'h0);
    step();
    check("byte_c3_wr",    32'(mem_wr1), 32'h1);
    check("byte_c3_wdata", mem_wdata1,   32'h112233AB);
    step();
    check("byte_c4_done",  32'(done1),   32'h1);
    check("byte_one_rd",   32'(rd_cnt1 - b_rd1), 32'h1);
    repeat (3) step();

    // Lane placement table on the latency-1 instance
    for (int i = 0; i < 5; i++) begin
      do_start(lane_size[i], lane_addr[i], lane_wd[i]);
      step(); step();
      check($sformatf("lane%0d_wdata", i), mem_wdata1, lane_exp[i]);
      repeat (4) step();
    end

    // Halfword store, RD_LATENCY=3
    mem_word3 = 32'hAABBCCDD;
    do_start(2'b01, 32'h40, 32'hFFFF1234);
    check("half_c1_rd",   32'(mem_rd3), 32'h1);
    check("half_c1_addr", mem_addr3,    32'h40);
    repeat (3) step();
    check("half_c4_wr",    32'(mem_wr3), 32'h0);
    step();
    check("half_c5_wr",    32'(mem_wr3), 32'h1);
    check("half_c5_wdata", mem_wdata3,   32'h1234CCDD);
    step();
    check("half_c6_done",  32'(done3),   32'h1);
    step();
    check("half_c7_busy",  32'(busy3),   32'h0);

    // Misaligned and illegal requests
    for (int i = 0; i < 3; i++) begin
      b_rd1 = rd_cnt1; b_wr1 = wr_cnt1; b_rd3 = rd_cnt3; b_wr3 = wr_cnt3;
      do_start(mis_size[i], mis_addr[i], 32'hFFFFFFFF);
      check($sformatf("mis%0d_c1_flag1", i), 32'(misalign1), 32'h1);
      check($sformatf("mis%0d_c1_flag3", i), 32'(misalign3), 32'h1);
      step();
      check($sformatf("mis%0d_c2_busy", i), 32'(busy1 | busy3), 32'h0);
      check($sformatf("mis%0d_c2_flag", i), 32'(misalign1), 32'h0);
      check($sformatf("mis%0d_no_mem", i),
            32'(rd_cnt1 - b_rd1 + wr_cnt1 - b_wr1 + rd_cnt3 - b_rd3 + wr_cnt3 - b_wr3), 32'h0);
    end

    // Reset during WAIT of a byte store
    mem_word3 = 32'h11223344;
    do_start(2'b10, 32'h203, 32'hAB);
    step();
    check("rmid_c2_busy", 32'(busy3), 32'h1);
    reset = 1'b1;
    step();
    check("rmid_busy",  32'(busy3),  32'h0);
    check("rmid_wr",    32'(mem_wr3), 32'h0);
    check("rmid_addr",  mem_addr3,   32'h0);
    reset = 1'b0;
    step();
    check("rmid_post_wr", 32'(mem_wr3), 32'h0);
    do_start(2'b00, 32'h80, 32'hCAFEF00D);
    check("rmid_new_wr",    32'(mem_wr3), 32'h1);
    check("rmid_new_addr",  mem_addr3,    32'h80);
    check("rmid_new_wdata", mem_wdata3,   32'hCAFEF00D);
    repeat (2) step();

    // Start pulsed during WAIT must be ignored
    mem_word3 = 32'hAABBCCDD;
    do_start(2'b10, 32'h201, 32'hCD);
    step();
    size = 2'b00; addr = 32'h500; wdata = 32'h12345678; start = 1'b1;
    step();
    start = 1'b0;
    check("busy_c3_addr", mem_addr3, 32'h200);
    step(); step();
    check("busy_c5_wr",    32'(mem_wr3), 32'h1);
    check("busy_c5_wdata", mem_wdata3,   32'hAACDCCDD);
    check("busy_c5_addr",  mem_addr3,    32'h200);
    step();
    check("busy_c6_done",  32'(done3),   32'h1);
    step();
    check("busy_c7_idle",  32'(busy3),   32'h0);
    check("busy_c7_addr",  mem_addr3,    32'h200);
    check("dut1_ignored",  mem_addr1,    32'h200);

    check("rd_wr_exclusive", 32'(overlap), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
